// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// instruction size and the default halt sentinel.
package cpu_fetch_pkg;

   // Fetch sequencer states; the encoding is visible to anyone probing r_state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_VALID  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

   // Bytes per instruction word (big-endian, one byte read per cycle).
   localparam int INST_BYTES = 4;

   // Sentinel instruction that stops fetch when halt detection is built in.
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFF0;

endpackage

// File: rtl/imem_fetch_ctrl_byte_assembler.sv
// fetch_byte_assembler: shifts one instruction byte per cycle into a word,
// most significant byte first, and counts how many bytes have been taken.
// o_word already contains the byte presented this cycle, so the owner can
// latch a complete instruction on the same edge that takes the last byte.
import cpu_fetch_pkg::*;

module fetch_byte_assembler (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_shift_en,
   input  logic [7:0]  i_byte_in,
   output logic [31:0] o_word,
   output logic [1:0]  o_byte_cnt,
   output logic        o_last
);

   logic [8*(INST_BYTES-1)-1:0] r_shift;
   logic [1:0]                  r_byte_cnt;

   // Shift register and byte counter; clear drops any partially assembled word.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_shift    <= '0;
         r_byte_cnt <= 2'd0;
      end else if (i_shift_en) begin
         r_shift    <= {r_shift[8*(INST_BYTES-2)-1:0], i_byte_in};
         r_byte_cnt <= r_byte_cnt + 2'd1;
      end
   end

   assign o_word     = {r_shift, i_byte_in};
   assign o_byte_cnt = r_byte_cnt;
   assign o_last     = (r_byte_cnt == 2'(INST_BYTES - 1));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer in front of the byte-wide instruction store.
// Owns the fetch PC, assembles big-endian 32-bit instructions and offers them
// to decode over a valid/ready handshake. Redirects restart fetch at an
// aligned target. Optional macro HALT_DETECT_EN stops fetch on a sentinel word.
import cpu_fetch_pkg::*;

module imem_fetch_ctrl #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
`ifdef HALT_DETECT_EN
   ,
   parameter logic [31:0]       HALT_WORD = HALT_WORD_DEFAULT
`endif
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_rdata,
   output logic              o_inst_valid,
   input  logic              i_inst_ready,
   output logic [31:0]       o_inst_word,
   output logic [ADDR_W-1:0] o_inst_pc,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_busy,
   output logic              o_halted
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic              r_inst_valid;
   logic              w_valid_next;
   logic [31:0]       r_inst_word;
   logic [ADDR_W-1:0] r_inst_pc;
   logic              w_latch;
   logic              w_shift_en;
   logic              w_clear;
   logic [31:0]       w_word;
   logic [1:0]        w_byte_cnt;
   logic              w_last;
   logic [ADDR_W-1:0] w_redirect_target;

   fetch_byte_assembler u_assembler (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_clear),
      .i_shift_en (w_shift_en),
      .i_byte_in  (i_mem_rdata),
      .o_word     (w_word),
      .o_byte_cnt (w_byte_cnt),
      .o_last     (w_last)
   );

   // Redirect targets are always word aligned.
   assign w_redirect_target = {i_redirect_pc[ADDR_W-1:2], 2'b00};

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, PC update and assembler control for each state.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_valid_next = r_inst_valid;
      w_latch      = 1'b0;
      w_shift_en   = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_redirect_valid) begin
               w_pc_next = w_redirect_target;
            end
            if (i_start) begin
               w_state_next = ST_FETCH;
               w_clear      = 1'b1;
            end
         end
         ST_FETCH: begin
            if (i_redirect_valid) begin
               w_pc_next    = w_redirect_target;
               w_clear      = 1'b1;
               w_valid_next = 1'b0;
            end else begin
               w_shift_en = 1'b1;
               if (w_last) begin
`ifdef HALT_DETECT_EN
                  if (w_word == HALT_WORD) begin
                     w_state_next = ST_HALTED;
                  end else begin
                     w_state_next = ST_VALID;
                     w_valid_next = 1'b1;
                     w_latch      = 1'b1;
                  end
`else
                  w_state_next = ST_VALID;
                  w_valid_next = 1'b1;
                  w_latch      = 1'b1;
`endif
               end
            end
         end
         ST_VALID: begin
            if (i_redirect_valid) begin
               w_pc_next    = w_redirect_target;
               w_clear      = 1'b1;
               w_valid_next = 1'b0;
               w_state_next = ST_FETCH;
            end else if (i_inst_ready) begin
               w_pc_next    = r_pc + ADDR_W'(INST_BYTES);
               w_valid_next = 1'b0;
               w_state_next = ST_FETCH;
            end
         end
         default: begin
            w_valid_next = 1'b0;
         end
      endcase
   end

   // PC and handshake registers; the instruction is captured with its own PC.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc         <= RESET_PC;
         r_inst_valid <= 1'b0;
         r_inst_word  <= '0;
         r_inst_pc    <= RESET_PC;
      end else begin
         r_pc         <= w_pc_next;
         r_inst_valid <= w_valid_next;
         if (w_latch) begin
            r_inst_word <= w_word;
            r_inst_pc   <= r_pc;
         end
      end
   end

   assign o_mem_addr   = r_pc + {{(ADDR_W-2){1'b0}}, w_byte_cnt};
   assign o_inst_valid = r_inst_valid;
   assign o_inst_word  = r_inst_word;
   assign o_inst_pc    = r_inst_pc;
   assign o_busy       = (r_state == ST_FETCH) || (r_state == ST_VALID);
`ifdef HALT_DETECT_EN
   assign o_halted     = (r_state == ST_HALTED);
`else
   assign o_halted     = 1'b0;
`endif

endmodule
